if_id_skid: RTL and testbench

Parametrised IF/ID pipeline stage with a valid/ready handshake and a two-entry skid buffer. It sits between the fetch unit (PC+4, fetched instruction) and the decode stage. The block sustains one instruction per cycle under downstream backpressure without a combinational ready path from decode to fetch. It supports flush (branch/jump redirect), a breakpoint hold, NOP injection when empty, and a saturating backpressure-cycle counter for debug.

---
 rtl/if_id_skid.sv | 148 ++++++++++++++
 tb/tb_if_id_skid.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// if_id_skid: IF/ID pipeline register with a valid/ready handshake and a
// two-entry skid buffer. in_ready is driven only by registered state and
// hold, so decode's out_ready never reaches fetch combinationally.
// Also supports a flush redirect, a breakpoint hold, a NOP bubble on the
// output while empty, and a saturating backpressure-cycle counter.
module if_id_skid #(
    parameter int unsigned        PC_W    = 32,
    parameter int unsigned        INS_W   = 32,
    parameter logic [INS_W-1:0]   NOP_INS = '0,
    parameter int unsigned        CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_npc,
    input  logic [INS_W-1:0] in_ins,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_npc,
    output logic [INS_W-1:0] out_ins,
    output logic [CNT_W-1:0] stall_cnt
);

    // Occupancy of the stage: nothing, main only, or main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [PC_W-1:0]    main_npc_q, main_npc_d;
    logic [INS_W-1:0]   main_ins_q, main_ins_d;
    logic [PC_W-1:0]    skid_npc_q, skid_npc_d;
    logic [INS_W-1:0]   skid_ins_q, skid_ins_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic acc;
    logic fire;
    logic stall_inc;

    // Handshake outputs come straight from registered state and hold.
    always_comb begin
        in_ready  = ~hold & (state_q != ST_TWO);
        out_valid = ~hold & (state_q != ST_EMPTY);
        out_npc   = main_npc_q;
        out_ins   = main_ins_q;
        stall_cnt = stall_cnt_q;
        acc       = in_valid & in_ready;
        fire      = out_valid & out_ready;
    end

    // Next occupancy and entry contents; flush beats hold beats normal flow.
    always_comb begin
        // NOTE: every signal gets a default here first, so no path can leave
        // a value unassigned and turn this block into a latch.
        state_d    = state_q;
        main_npc_d = main_npc_q;
        main_ins_d = main_ins_q;
        skid_npc_d = skid_npc_q;
        skid_ins_d = skid_ins_q;

        if (flush) begin
            // Redirect: drop everything, including a same-cycle input transfer.
            state_d    = ST_EMPTY;
            main_npc_d = '0;
            main_ins_d = NOP_INS;
        end else if (!hold) begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_npc_d = in_npc;
                        main_ins_d = in_ins;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && fire) begin
                        // Head leaves and the new instruction replaces it.
                        main_npc_d = in_npc;
                        main_ins_d = in_ins;
                    end else if (acc) begin
                        // Decode is stalled: park the new one behind the head.
                        skid_npc_d = in_npc;
                        skid_ins_d = in_ins;
                        state_d    = ST_TWO;
                    end else if (fire) begin
                        // Last entry consumed: present a NOP bubble.
                        main_npc_d = '0;
                        main_ins_d = NOP_INS;
                        state_d    = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (fire) begin
                        // Skid drains into the head, keeping FIFO order.
                        main_npc_d = skid_npc_q;
                        main_ins_d = skid_ins_q;
                        state_d    = ST_ONE;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_npc_d = '0;
                    main_ins_d = NOP_INS;
                end
            endcase
        end
    end

    // Debug counter: cycles where decode is offered an instruction and refuses.
    always_comb begin
        stall_inc   = out_valid & ~out_ready & ~flush;
        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, head entry and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_npc_q  <= '0;
            main_ins_q  <= NOP_INS;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_npc_q  <= main_npc_d;
            main_ins_q  <= main_ins_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Skid entry data register.
    always_ff @(posedge clk) begin
        // NOTE: the skid entry has no reset; its contents are only read in
        // ST_TWO, which is always entered by writing it first.
        skid_npc_q <= skid_npc_d;
        skid_ins_q <= skid_ins_d;
    end

endmodule

// File: tb/tb_if_id_skid.sv
// tb_if_id_skid: directed-vector bench for if_id_skid. Each cycle drives the
// inputs, lets combinational outputs settle, compares against hand-computed
// values, then advances one clock edge.
module tb_if_id_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        hold;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_npc;
    logic [31:0] in_ins;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_npc;
    logic [31:0] out_ins;
    logic [3:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_skid #(
        .PC_W    (32),
        .INS_W   (32),
        .NOP_INS (NOP),
        .CNT_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_npc    (in_npc),
        .in_ins    (in_ins),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_npc   (out_npc),
        .out_ins   (out_ins),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, check settled outputs, then cross the edge.
    task automatic cyc(input string tag,
                       input logic f, input logic h, input logic v,
                       input logic [31:0] npc, input logic [31:0] ins, input logic r,
                       input logic e_ir, input logic e_ov,
                       input logic [31:0] e_npc, input logic [31:0] e_ins,
                       input int e_st);
        flush     = f;
        hold      = h;
        in_valid  = v;
        in_npc    = npc;
        in_ins    = ins;
        out_ready = r;
        #1;
        check({tag, "/in_ready"},  64'(in_ready),  64'(e_ir));
        check({tag, "/out_valid"}, 64'(out_valid), 64'(e_ov));
        check({tag, "/out_npc"},   64'(out_npc),   64'(e_npc));
        check({tag, "/out_ins"},   64'(out_ins),   64'(e_ins));
        check({tag, "/stall_cnt"}, 64'(stall_cnt), 64'(e_st));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
        in_npc = '0; in_ins = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        cyc("reset",   0,0,0, 32'h0,   32'h0,  0,   1,0, 32'h0,   NOP,    0);

        // Streaming: one per cycle, output one cycle behind input
        cyc("str0",    0,0,1, 32'd4,   32'h11, 1,   1,0, 32'h0,   NOP,    0);
        cyc("str1",    0,0,1, 32'd8,   32'h12, 1,   1,1, 32'd4,   32'h11, 0);
        cyc("str2",    0,0,1, 32'd12,  32'h13, 1,   1,1, 32'd8,   32'h12, 0);
        cyc("str3",    0,0,1, 32'd16,  32'h14, 1,   1,1, 32'd12,  32'h13, 0);
        cyc("str4",    0,0,1, 32'd20,  32'h15, 1,   1,1, 32'd16,  32'h14, 0);
        cyc("str5",    0,0,0, 32'h0,   32'h0,  1,   1,1, 32'd20,  32'h15, 0);
        cyc("str6",    0,0,0, 32'h0,   32'h0,  0,   1,0, 32'h0,   NOP,    0);

        // Backpressure: A held, B into skid, C waits, then A,B,C in order
        cyc("bp0",     0,0,1, 32'h100, 32'hA0, 1,   1,0, 32'h0,   NOP,    0);
        cyc("bp1",     0,0,1, 32'h104, 32'hB0, 0,   1,1, 32'h100, 32'hA0, 0);
        cyc("bp2",     0,0,1, 32'h108, 32'hC0, 0,   0,1, 32'h100, 32'hA0, 1);
        cyc("bp3",     0,0,1, 32'h108, 32'hC0, 0,   0,1, 32'h100, 32'hA0, 2);
        cyc("bp4",     0,0,1, 32'h108, 32'hC0, 1,   0,1, 32'h100, 32'hA0, 3);
        cyc("bp5",     0,0,1, 32'h108, 32'hC0, 1,   1,1, 32'h104, 32'hB0, 3);
        cyc("bp6",     0,0,0, 32'h0,   32'h0,  1,   1,1, 32'h108, 32'hC0, 3);
        cyc("bp7",     0,0,0, 32'h0,   32'h0,  0,   1,0, 32'h0,   NOP,    3);

        // Flush in TWO with 0xDEAD on the input, then flush in ONE with an accept
        cyc("fl0",     0,0,1, 32'h200, 32'hD1, 1,   1,0, 32'h0,   NOP,    3);
        cyc("fl1",     0,0,1, 32'h204, 32'hD2, 0,   1,1, 32'h200, 32'hD1, 3);
        cyc("fl2",     1,0,1, 32'h208, 32'hDEAD,1,  0,1, 32'h200, 32'hD1, 4);
        cyc("fl3",     0,0,1, 32'h20C, 32'hE1, 1,   1,0, 32'h0,   NOP,    4);
        cyc("fl4",     0,0,1, 32'h210, 32'hE2, 1,   1,1, 32'h20C, 32'hE1, 4);
        cyc("fl5",     1,0,1, 32'h214, 32'hDEAD,1,  1,1, 32'h210, 32'hE2, 4);
        cyc("fl6",     0,0,0, 32'h0,   32'h0,  1,   1,0, 32'h0,   NOP,    4);
        cyc("fl7",     0,0,1, 32'h218, 32'hE3, 0,   1,0, 32'h0,   NOP,    4);

        // Hold for 4 cycles in ONE: frozen, no handshakes, counter idle
        cyc("hold0",   0,1,1, 32'h21C, 32'hF1, 1,   0,0, 32'h218, 32'hE3, 4);
        cyc("hold1",   0,1,1, 32'h21C, 32'hF1, 1,   0,0, 32'h218, 32'hE3, 4);
        cyc("hold2",   0,1,1, 32'h21C, 32'hF1, 1,   0,0, 32'h218, 32'hE3, 4);
        cyc("hold3",   0,1,1, 32'h21C, 32'hF1, 1,   0,0, 32'h218, 32'hE3, 4);
        cyc("hold4",   0,0,0, 32'h0,   32'h0,  0,   1,1, 32'h218, 32'hE3, 4);
        cyc("hold5",   0,0,0, 32'h0,   32'h0,  1,   1,1, 32'h218, 32'hE3, 5);
        cyc("hold6",   0,0,0, 32'h0,   32'h0,  0,   1,0, 32'h0,   NOP,    5);

        // Saturation: 20 refused cycles take the 4-bit counter from 5 to 15
        cyc("sat_ld",  0,0,1, 32'h300, 32'hAA, 0,   1,0, 32'h0,   NOP,    5);
        for (int k = 0; k < 20; k++) begin
            cyc($sformatf("sat%0d", k), 0,0,0, 32'h0, 32'h0, 0,
                1,1, 32'h300, 32'hAA, (5 + k > 15) ? 15 : 5 + k);
        end
        cyc("sat_two", 0,0,1, 32'h304, 32'hBB, 0,   1,1, 32'h300, 32'hAA, 15);

        // Reset while in TWO: rst wins over the pending input
        rst = 1'b1; in_valid = 1'b1; in_npc = 32'h308; in_ins = 32'hCC; out_ready = 1'b0;
        #1;
        check("rst_two/in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("post_rst0", 0,0,1, 32'h400, 32'hC1, 0, 1,0, 32'h0,   NOP,    0);
        cyc("post_rst1", 0,0,0, 32'h0,   32'h0,  1, 1,1, 32'h400, 32'hC1, 0);
        cyc("post_rst2", 0,0,0, 32'h0,   32'h0,  0, 1,0, 32'h0,   NOP,    0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
